// File: rtl/wb_regfile_if.sv
// Write-back stage bundle: retiring MEM/WB slot, ID-stage read ports,
// forwarding outputs and retirement status.
interface wb_regfile_if #(
    parameter int RETIRE_W = 32
);
    logic                valid_in;
    logic [31:0]         LMD_in;
    logic [31:0]         ALU_output_in;
    logic [31:0]         IR_in;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [31:0]         rs1_data;
    logic [31:0]         rs2_data;
    logic                wb_en_out;
    logic [4:0]          wb_addr_out;
    logic [31:0]         wb_data_out;
    logic                halted;
    logic [RETIRE_W-1:0] retired_count;

    modport master (
        output valid_in, LMD_in, ALU_output_in, IR_in, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_en_out, wb_addr_out, wb_data_out,
               halted, retired_count
    );

    modport slave (
        input  valid_in, LMD_in, ALU_output_in, IR_in, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_en_out, wb_addr_out, wb_data_out,
               halted, retired_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage with 32x32 register file, write-first read bypass,
// HLT-driven RUN/HALTED state machine and retired-instruction counter.
module wb_regfile #(
    parameter int RETIRE_W = 32
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_HALTED} state_t;
    typedef enum logic [1:0] {CL_NONE, CL_RALU, CL_IALU, CL_LOAD} wb_class_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    state_t              state_q;
    logic                halted_q;
    logic [RETIRE_W-1:0] count_q;
    logic [31:0]         regs [32];

    logic [5:0]  opcode;
    wb_class_t   wb_class;
    logic [4:0]  dest;
    logic [31:0] wr_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        unused_ir;

    assign opcode    = bus.IR_in[31:26];
    assign unused_ir = ^{bus.IR_in[25:21], bus.IR_in[10:0]};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        wb_class = CL_NONE;
        dest     = '0;
        wr_data  = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: wb_class = CL_RALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     wb_class = CL_IALU;
            OP_LW:                                         wb_class = CL_LOAD;
            default:                                       wb_class = CL_NONE;
        endcase
        case (wb_class)
            CL_RALU: begin
                dest    = bus.IR_in[15:11];
                wr_data = bus.ALU_output_in;
            end
            CL_IALU: begin
                dest    = bus.IR_in[20:16];
                wr_data = bus.ALU_output_in;
            end
            CL_LOAD: begin
                dest    = bus.IR_in[20:16];
                wr_data = bus.LMD_in;
            end
            default: ;
        endcase
    end

    // r0 is excluded here, so it can never be written and needs no special read path
    assign wb_en   = bus.valid_in && (state_q == ST_RUN) && (wb_class != CL_NONE)
                     && (dest != 5'd0) && !rst;
    assign wb_addr = wb_en ? dest    : 5'd0;
    assign wb_data = wb_en ? wr_data : 32'd0;

    assign bus.wb_en_out   = wb_en;
    assign bus.wb_addr_out = wb_addr;
    assign bus.wb_data_out = wb_data;

    assign bus.rs1_data = (bus.rs1_addr == 5'd0)                 ? 32'd0   :
                          (wb_en && bus.rs1_addr == wb_addr)     ? wb_data :
                                                                   regs[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == 5'd0)                 ? 32'd0   :
                          (wb_en && bus.rs2_addr == wb_addr)     ? wb_data :
                                                                   regs[bus.rs2_addr];

    // NOTE: the register array is reset explicitly because reads after reset must return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.valid_in) begin
                        count_q <= count_q + RETIRE_W'(1);
                        if (opcode == OP_HLT) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.halted        = halted_q;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares the combinational and registered outputs.
module tb_wb_regfile;
    localparam int RW = 4;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_UNK  = 6'b111110;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    typedef struct {
        string       name;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        halt;
        logic [RW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    wb_regfile_if #(.RETIRE_W(RW)) bus ();

    wb_regfile #(.RETIRE_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {op, 5'd0, rt, rd, 11'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what the outputs must show.
    task automatic vec(input string name, input logic r, input logic v,
                       input logic [31:0] ir, input logic [31:0] lmd, input logic [31:0] alu,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_data,
                       input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                       input logic e_halt, input logic [RW-1:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bus.valid_in      = v;
        bus.IR_in         = ir;
        bus.LMD_in        = lmd;
        bus.ALU_output_in = alu;
        bus.rs1_addr      = a1;
        bus.rs2_addr      = a2;
        e.name = name; e.en = e_en; e.addr = e_addr; e.data = e_data;
        e.rs1 = e_rs1; e.rs2 = e_rs2; e.halt = e_halt; e.cnt = e_cnt;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vectors++;
                check({e.name, ".wb_en"},   32'(bus.wb_en_out),     32'(e.en));
                check({e.name, ".wb_addr"}, 32'(bus.wb_addr_out),   32'(e.addr));
                check({e.name, ".wb_data"}, bus.wb_data_out,        e.data);
                check({e.name, ".rs1"},     bus.rs1_data,           e.rs1);
                check({e.name, ".rs2"},     bus.rs2_data,           e.rs2);
                check({e.name, ".halted"},  32'(bus.halted),        32'(e.halt));
                check({e.name, ".count"},   32'(bus.retired_count), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.IR_in = '0; bus.LMD_in = '0; bus.ALU_output_in = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0;
        @(posedge clk);

        //   name        rst  v   IR                          LMD           ALU           a1     a2     en  addr   data          rs1           rs2           h  cnt
        vec("reset",     1, 0, 32'd0,                       32'd0,        32'd0,        5'd3,  5'd0,  0, 5'd0,  32'd0,        32'd0,        32'd0,        0, 4'd0);
        vec("add_r3",    0, 1, mk_ir(OP_ADD, 5'd0, 5'd3),    32'd0,        32'h15,       5'd3,  5'd3,  1, 5'd3,  32'h15,       32'h15,       32'h15,       0, 4'd0);
        vec("bubble0",   0, 0, 32'd0,                       32'd0,        32'd0,        5'd3,  5'd7,  0, 5'd0,  32'd0,        32'h15,       32'd0,        0, 4'd1);
        vec("lw_r7",     0, 1, mk_ir(OP_LW, 5'd7, 5'd5),     32'hDEADBEEF, 32'h40,       5'd7,  5'd3,  1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h15,       0, 4'd1);
        vec("addi_r0",   0, 1, mk_ir(OP_ADDI, 5'd0, 5'd6),   32'd0,        32'h55,       5'd0,  5'd7,  0, 5'd0,  32'd0,        32'd0,        32'hDEADBEEF, 0, 4'd2);
        vec("sw",        0, 1, mk_ir(OP_SW, 5'd3, 5'd3),     32'h1234,     32'h77,       5'd3,  5'd7,  0, 5'd0,  32'd0,        32'h15,       32'hDEADBEEF, 0, 4'd3);
        vec("beqz",      0, 1, mk_ir(OP_BEQZ, 5'd3, 5'd3),   32'h1234,     32'h77,       5'd6,  5'd3,  0, 5'd0,  32'd0,        32'd0,        32'h15,       0, 4'd4);
        vec("unk_3e",    0, 1, mk_ir(OP_UNK, 5'd3, 5'd3),    32'h1234,     32'h77,       5'd3,  5'd7,  0, 5'd0,  32'd0,        32'h15,       32'hDEADBEEF, 0, 4'd5);
        vec("bubble1",   0, 0, mk_ir(OP_ADD, 5'd0, 5'd3),    32'd0,        32'h66,       5'd3,  5'd0,  0, 5'd0,  32'd0,        32'h15,       32'd0,        0, 4'd6);
        vec("sub_r4",    0, 1, mk_ir(OP_SUB, 5'd0, 5'd4),    32'd0,        32'h22,       5'd4,  5'd4,  1, 5'd4,  32'h22,       32'h22,       32'h22,       0, 4'd6);
        vec("mul_r31",   0, 1, mk_ir(OP_MUL, 5'd0, 5'd31),   32'd0,        32'hA5A5A5A5, 5'd31, 5'd4,  1, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h22,       0, 4'd7);
        vec("slti_r9",   0, 1, mk_ir(OP_SLTI, 5'd9, 5'd12),  32'd0,        32'h1,        5'd9,  5'd12, 1, 5'd9,  32'h1,        32'h1,        32'd0,        0, 4'd8);
        vec("hlt",       0, 1, mk_ir(OP_HLT, 5'd4, 5'd4),    32'd0,        32'h33,       5'd4,  5'd9,  0, 5'd0,  32'd0,        32'h22,       32'h1,        0, 4'd9);
        vec("post_hlt",  0, 1, mk_ir(OP_ADD, 5'd0, 5'd4),    32'd0,        32'h99,       5'd4,  5'd31, 0, 5'd0,  32'd0,        32'h22,       32'hA5A5A5A5, 1, 4'd10);
        vec("halted_rd", 0, 0, 32'd0,                       32'd0,        32'd0,        5'd4,  5'd9,  0, 5'd0,  32'd0,        32'h22,       32'h1,        1, 4'd10);
        vec("rst_halt",  1, 0, 32'd0,                       32'd0,        32'd0,        5'd4,  5'd31, 0, 5'd0,  32'd0,        32'h22,       32'hA5A5A5A5, 1, 4'd10);
        vec("after_rst", 0, 0, 32'd0,                       32'd0,        32'd0,        5'd4,  5'd31, 0, 5'd0,  32'd0,        32'd0,        32'd0,        0, 4'd0);

        // Sixteen retirements wrap the 4-bit counter back to 0 on the last one.
        for (int i = 0; i <= 16; i++) begin
            vec($sformatf("or_wrap%0d", i), 0, 1, mk_ir(OP_OR, 5'd0, 5'd1), 32'd0, 32'(i),
                5'd1, 5'd0, 1, 5'd1, 32'(i), 32'(i), 32'd0, 0, RW'(i));
        end

        vec("rst_add_r5", 1, 1, mk_ir(OP_ADD, 5'd0, 5'd5),   32'd0,        32'h11,       5'd5,  5'd1,  0, 5'd0,  32'd0,        32'd0,        32'd16,       0, 4'd1);
        vec("after_rst2", 0, 0, 32'd0,                       32'd0,        32'd0,        5'd5,  5'd1,  0, 5'd0,  32'd0,        32'd0,        32'd0,        0, 4'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
